// File: rtl/display_data_mc.sv
// display_data_mc: channel select, reference cursor and cursor time-interval engine.
// Define LS_BTN_DEBOUNCE_EN to add a DB_CYC-cycle debounce after each button synchroniser.
module display_data_mc #(
  parameter int NCH       = 4,
  parameter int XW        = 10,
  parameter int SW        = 8,
  parameter int TW        = 17,
  parameter int NS_PER_PX = 5,
  parameter int SCAN_BASE = 7,
  parameter int TMAX      = 99840,
  parameter int DB_CYC    = 250000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sel_ch_btn,
  input  logic           curs_set_btn,
  input  logic [XW-1:0]  curs_x,
  input  logic [SW-1:0]  scan_data,
  input  logic [XW-1:0]  scan_n,
  input  logic           frame,
  output logic [NCH-1:0] sel_channel,
  output logic           set_curs,
  output logic [XW-1:0]  first_curs_x,
  output logic [TW-1:0]  curr_val,
  output logic [TW-1:0]  first_val,
  output logic [TW-1:0]  diff_val,
  output logic           diff_neg,
  output logic           val_valid,
  output logic [4:0]     dbg_state
);
  localparam int PW = XW + 3 + SCAN_BASE + 1;
  localparam int CW = $clog2(PW);
  localparam logic [NCH-1:0] CH_MSB = NCH'(1) << (NCH - 1);

  // Button front end: bit 0 = channel select, bit 1 = cursor set; low = pressed.
  logic [1:0] btn_raw, sync1, sync2, cond, cond_q, press, rel;
  assign btn_raw = {curs_set_btn, sel_ch_btn};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      cond_q <= 2'b11;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      cond_q <= cond;
    end
  end

`ifdef LS_BTN_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYC + 1);
  logic [DBW-1:0] db_cnt [2];
  logic [1:0]     db_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_out    <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_out[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYC - 1)) begin
          db_out[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign cond = db_out;
`else
  assign cond = sync2;
`endif

  assign press = cond_q & ~cond;
  assign rel   = ~cond_q & cond;

  // Channel select FSM
  typedef enum logic [1:0] {INI, WAIT_PRESS, WAIT_REL} ch_state_t;
  ch_state_t      ch_state, ch_next;
  logic [NCH-1:0] sel_next;

  always_comb begin
    ch_next  = ch_state;
    sel_next = sel_channel;
    case (ch_state)
      INI: begin
        sel_next = '1;
        ch_next  = WAIT_PRESS;
      end
      WAIT_PRESS: if (press[0]) ch_next = WAIT_REL;
      WAIT_REL: if (rel[0]) begin
        if (sel_channel == '1 || sel_channel == CH_MSB) sel_next = NCH'(1);
        else                                            sel_next = sel_channel << 1;
        ch_next = WAIT_PRESS;
      end
      default: ch_next = INI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_state    <= INI;
      sel_channel <= '1;
    end else begin
      ch_state    <= ch_next;
      sel_channel <= sel_next;
    end
  end

  // Reference cursor FSM; a timebase change while set overrides a coincident release.
  typedef enum logic {C_IDLE, C_PRESSED} c_state_t;
  c_state_t      c_state, c_next;
  logic          arm, arm_next, set_next, inval;
  logic [SW-1:0] lat_sd;
  logic [XW-1:0] lat_sn;

  assign inval = set_curs && (scan_data != lat_sd || scan_n != lat_sn);

  always_comb begin
    c_next   = c_state;
    arm_next = arm;
    set_next = set_curs;
    case (c_state)
      C_IDLE: if (press[1]) begin
        arm_next = !set_curs && (curs_x > XW'(4));
        c_next   = C_PRESSED;
      end
      C_PRESSED: if (rel[1]) begin
        set_next = arm;
        c_next   = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
    if (inval) set_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state  <= C_IDLE;
      arm      <= 1'b0;
      set_curs <= 1'b0;
      lat_sd   <= '0;
      lat_sn   <= '0;
    end else begin
      c_state  <= c_next;
      arm      <= arm_next;
      set_curs <= set_next;
      if (!set_curs) begin
        lat_sd <= scan_data;
        lat_sn <= scan_n;
      end
    end
  end

  // Time engine. val_valid is a one-cycle strobe with no back-pressure: the overlay
  // samples curr_val/first_val/diff_val/diff_neg on it, and they hold until the next strobe.
  typedef enum logic [1:0] {T_IDLE, T_MUL, T_DIV, T_SAT} t_state_t;
  t_state_t      t_state, t_next;
  logic [XW-1:0] t_col;
  logic [SW-1:0] t_sd;
  logic [PW-1:0] quo, rem, prod, rem_sh, dvs;
  logic [CW-1:0] bcnt;
  logic [TW-1:0] r;
  logic          mul_region;

  assign mul_region = t_sd <= SW'(SCAN_BASE);
  assign prod       = PW'(t_col) * PW'(NS_PER_PX);
  assign dvs        = PW'(t_sd - SW'(SCAN_BASE));
  assign rem_sh     = {rem[PW-2:0], quo[PW-1]};
  assign r          = (quo > PW'(TMAX)) ? TW'(TMAX) : quo[TW-1:0];

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:  if (frame) t_next = T_MUL;
      T_MUL:   t_next = mul_region ? T_SAT : T_DIV;
      T_DIV:   if (bcnt == CW'(PW - 1)) t_next = T_SAT;
      T_SAT:   t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state      <= T_IDLE;
      t_col        <= '0;
      t_sd         <= '0;
      quo          <= '0;
      rem          <= '0;
      bcnt         <= '0;
      curr_val     <= '0;
      first_val    <= '0;
      first_curs_x <= '0;
      diff_val     <= '0;
      diff_neg     <= 1'b0;
      val_valid    <= 1'b0;
    end else begin
      t_state   <= t_next;
      val_valid <= 1'b0;
      case (t_state)
        T_IDLE: if (frame) begin
          t_col <= curs_x;
          t_sd  <= scan_data;
        end
        T_MUL: begin
          quo  <= mul_region ? (prod << (SW'(SCAN_BASE + 1) - t_sd)) : prod;
          rem  <= '0;
          bcnt <= '0;
        end
        T_DIV: begin
          if (rem_sh >= dvs) begin
            rem <= rem_sh - dvs;
            quo <= {quo[PW-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[PW-2:0], 1'b0};
          end
          bcnt <= bcnt + 1'b1;
        end
        T_SAT: begin
          curr_val  <= r;
          val_valid <= 1'b1;
          if (set_curs) begin
            diff_val <= (r >= first_val) ? r - first_val : first_val - r;
            diff_neg <= t_col < first_curs_x;
          end else begin
            first_val    <= r;
            first_curs_x <= t_col;
            diff_val     <= '0;
            diff_neg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = {ch_state, c_state, t_state};
endmodule

// File: tb/tb_display_data_mc.sv
// Bench for display_data_mc: directed + random frames checked through an expected queue.
module tb_display_data_mc;
  localparam int NCH = 4, XW = 10, SW = 8, TW = 17, DB = 16;
  localparam int PW  = XW + 3 + 7 + 1;
  localparam int EW  = 3 * TW + 1 + XW + 32;

  // clock / reset
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           sel_ch_btn = 1'b1, curs_set_btn = 1'b1, frame = 1'b0;
  logic [XW-1:0]  curs_x = '0, scan_n = '0;
  logic [SW-1:0]  scan_data = '0;
  logic [NCH-1:0] sel_channel;
  logic           set_curs, diff_neg, val_valid;
  logic [XW-1:0]  first_curs_x;
  logic [TW-1:0]  curr_val, first_val, diff_val;
  logic [4:0]     dbg_state;

  display_data_mc #(.NCH(NCH), .XW(XW), .SW(SW), .TW(TW), .DB_CYC(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sel_ch_btn(sel_ch_btn), .curs_set_btn(curs_set_btn),
    .curs_x(curs_x), .scan_data(scan_data), .scan_n(scan_n), .frame(frame),
    .sel_channel(sel_channel), .set_curs(set_curs), .first_curs_x(first_curs_x),
    .curr_val(curr_val), .first_val(first_val), .diff_val(diff_val),
    .diff_neg(diff_neg), .val_valid(val_valid), .dbg_state(dbg_state));

  int n_vec = 0, n_fail = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  logic [NCH-1:0] m_sel;
  bit             m_set;
  longint         m_first;
  int             m_first_x, m_lat_sd, m_lat_sn, live_sd, live_sn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint ref_time(input int x, input int sd);
    longint ns;
    ns = longint'(x) * 5;
    if (sd <= 7) ns = ns * (longint'(1) << (8 - sd));
    else         ns = ns / (sd - 7);
    if (ns > 99840) ns = 99840;
    return ns;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [TW-1:0] e_curr, e_first, e_diff;
    logic          e_neg;
    logic [XW-1:0] e_fx;
    logic [31:0]   e_cyc;
    if (rst_n && val_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_valid: got pulse at cycle %0d curr_val=%0d, required none", cyc, curr_val);
      end else begin
        e = exp_q.pop_front();
        {e_curr, e_first, e_diff, e_neg, e_fx, e_cyc} = e;
        check("curr_val",     64'(curr_val),     64'(e_curr));
        check("first_val",    64'(first_val),    64'(e_first));
        check("diff_val",     64'(diff_val),     64'(e_diff));
        check("diff_neg",     64'(diff_neg),     64'(e_neg));
        check("first_curs_x", 64'(first_curs_x), 64'(e_fx));
        check("latency_cycle", 64'(cyc),         64'(e_cyc));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_scan(input int sd, input int sn);
    scan_data = SW'(sd);
    scan_n    = XW'(sn);
    live_sd   = sd;
    live_sn   = sn;
    if (m_set && (sd != m_lat_sd || sn != m_lat_sn)) m_set = 1'b0;
    if (!m_set) begin
      m_lat_sd = sd;
      m_lat_sn = sn;
    end
  endtask

  task automatic model_reset();
    m_sel = '1; m_set = 1'b0; m_first = 0; m_first_x = 0;
    m_lat_sd = live_sd; m_lat_sn = live_sn;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL val_valid_timeout: got %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic sel_press();
    sel_ch_btn = 1'b0; tick(30);
    sel_ch_btn = 1'b1; tick(30);
    if (m_sel == '1 || m_sel == (NCH'(1) << (NCH - 1))) m_sel = NCH'(1);
    else m_sel = m_sel << 1;
    check("sel_channel", 64'(sel_channel), 64'(m_sel));
  endtask

  task automatic curs_press(input int x);
    curs_x = XW'(x);
    curs_set_btn = 1'b0; tick(30);
    curs_set_btn = 1'b1; tick(30);
    m_set = !m_set && (x > 4);
    check("set_curs", 64'(set_curs), 64'(m_set));
  endtask

  task automatic frame_go(input int x, input int sd, input int sn, input bit do_wait);
    longint r, d;
    bit     neg;
    set_scan(sd, sn);
    curs_x = XW'(x);
    r = ref_time(x, sd);
    if (!m_set) begin
      m_first = r; m_first_x = x; d = 0; neg = 1'b0;
    end else begin
      d   = (r >= m_first) ? r - m_first : m_first - r;
      neg = (x < m_first_x);
    end
    exp_q.push_back({TW'(r), TW'(m_first), TW'(d), neg, XW'(m_first_x),
                     32'(cyc + 1 + ((sd > 7) ? PW + 2 : 2))});
    frame = 1'b1; tick(1); frame = 1'b0;
    if (do_wait) wait_empty();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel_channel"},  64'(sel_channel),  64'(4'hF));
    check({tag, "_set_curs"},     64'(set_curs),     64'(0));
    check({tag, "_curr_val"},     64'(curr_val),     64'(0));
    check({tag, "_first_val"},    64'(first_val),    64'(0));
    check({tag, "_diff_val"},     64'(diff_val),     64'(0));
    check({tag, "_diff_neg"},     64'(diff_neg),     64'(0));
    check({tag, "_first_curs_x"}, 64'(first_curs_x), 64'(0));
    check({tag, "_val_valid"},    64'(val_valid),    64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, sd, sn;
    live_sd = 0; live_sn = 0;
    model_reset();
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(3);
    check_reset_outputs("post_reset");

    // channel rotation
    for (int i = 0; i < 5; i++) sel_press();
`ifdef LS_BTN_DEBOUNCE_EN
    sel_ch_btn = 1'b0; tick(10);
    sel_ch_btn = 1'b1; tick(30);
    check("glitch_sel_channel", 64'(sel_channel), 64'(m_sel));
`endif

    // divide region, multiply region, saturation
    frame_go(100, 9, 0, 1'b1);
    frame_go(100, 5, 0, 1'b1);
    frame_go(639, 0, 0, 1'b1);

    // reference cursor and interval
    frame_go(100, 9, 0, 1'b1);
    curs_press(100);
    frame_go(300, 9, 0, 1'b1);
    frame_go(40, 9, 0, 1'b1);

    // invalidation by scan_n change takes effect on the next clock
    set_scan(9, 5);
    tick(1);
    check("inval_set_curs", 64'(set_curs), 64'(m_set));
    frame_go(40, 9, 5, 1'b1);
    curs_press(3);
    curs_press(200);
    curs_press(200);

    // frame while busy is ignored
    frame_go(500, 12, 5, 1'b0);
    tick(5);
    curs_x = XW'(7); frame = 1'b1; tick(1); frame = 1'b0;
    wait_empty();
    tick(PW + 5);

    // random mix
    for (int i = 0; i < 25; i++) begin
      x  = $urandom_range(0, 1023);
      sd = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(8, 255);
      sn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : live_sn;
      if ($urandom_range(0, 3) == 0) curs_press($urandom_range(0, 1023));
      frame_go(x, sd, sn, 1'b1);
    end

    // reset in the middle of a division
    sel_press();
    frame_go(100, 9, live_sn, 1'b0);
    tick(10);
    rst_n = 1'b0;
    exp_q.delete();
    tick(2);
    check_reset_outputs("mid_div_reset");
    rst_n = 1'b1;
    model_reset();
    tick(PW + 6);
    check_reset_outputs("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
